dualmerge: RTL and testbench

Two-to-one merging arbiter with a registered output stage and packet lock; the inverse of the CPLD demux path, recombining two valid/ready streams onto one. Each accepted beat is tagged with its source on `q_msel` (0 = from channel 0), matching the `msel` convention of the splitting side, so a downstream demux can route replies back. It sits between two producer macrocell groups and a single shared consumer.

---
 rtl/dualmerge_if.sv | 29 ++
 rtl/dualmerge.sv | 104 ++++++++++
 tb/tb_dualmerge.sv | 217 +++++++++++++++++++++
 3 files changed

// File: rtl/dualmerge_if.sv
// Bundle for the two producer channels and the merged consumer channel of dualmerge.
// slave is the merger's view; master is the view of whatever drives the producers and consumer.
interface dualmerge_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] d0;
  logic             d0_valid;
  logic             d0_last;
  logic             d0_ready;
  logic [WIDTH-1:0] d1;
  logic             d1_valid;
  logic             d1_last;
  logic             d1_ready;
  logic [WIDTH-1:0] q;
  logic             q_valid;
  logic             q_last;
  logic             q_msel;
  logic             q_ready;

  modport slave (
    input  d0, d0_valid, d0_last, d1, d1_valid, d1_last, q_ready,
    output d0_ready, d1_ready, q, q_valid, q_last, q_msel
  );

  modport master (
    output d0, d0_valid, d0_last, d1, d1_valid, d1_last, q_ready,
    input  d0_ready, d1_ready, q, q_valid, q_last, q_msel
  );
endinterface

// File: rtl/dualmerge.sv
// Two-to-one round-robin merge with packet lock; one registered output stage, 1-cycle latency.
// Readies follow load = ~q_valid | q_ready, so a stalled consumer stops both producers with no bubble on release.
module dualmerge #(
  parameter int WIDTH = 8
) (
  input logic       clk,
  input logic       rst_n,
  dualmerge_if.slave m
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } state_t;

  state_t           state, state_nxt;
  logic             prio, prio_nxt;
  logic             grant0, grant1;
  logic             load;
  logic             acc0, acc1;
  logic [WIDTH-1:0] q_r;
  logic             q_valid_r;
  logic             q_last_r;
  logic             q_msel_r;

  assign load = ~q_valid_r | m.q_ready;
  // rst_n gate keeps both readies low for the whole reset window
  assign acc0 = load & grant0 & rst_n;
  assign acc1 = load & grant1 & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      prio  <= 1'b0;
    end else begin
      state <= state_nxt;
      prio  <= prio_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    prio_nxt  = prio;
    grant0    = 1'b0;
    grant1    = 1'b0;
    case (state)
      IDLE: begin
        if (m.d0_valid && m.d1_valid) begin
          grant0 = ~prio;
          grant1 = prio;
        end else begin
          grant0 = m.d0_valid;
          grant1 = m.d1_valid;
        end
      end
      // a locked packet owns the output even while its source is idle
      LOCK0:   grant0 = m.d0_valid;
      LOCK1:   grant1 = m.d1_valid;
      default: state_nxt = IDLE;
    endcase
    if (acc0) begin
      if (m.d0_last) begin
        state_nxt = IDLE;
        prio_nxt  = 1'b1;
      end else begin
        state_nxt = LOCK0;
      end
    end else if (acc1) begin
      if (m.d1_last) begin
        state_nxt = IDLE;
        prio_nxt  = 1'b0;
      end else begin
        state_nxt = LOCK1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_r       <= '0;
      q_valid_r <= 1'b0;
      q_last_r  <= 1'b0;
      q_msel_r  <= 1'b0;
    end else if (load) begin
      if (acc0 || acc1) begin
        q_r       <= acc1 ? m.d1 : m.d0;
        q_last_r  <= acc1 ? m.d1_last : m.d0_last;
        q_msel_r  <= acc1;
        q_valid_r <= 1'b1;
      end else begin
        q_valid_r <= 1'b0;
      end
    end
  end

  assign m.d0_ready = acc0;
  assign m.d1_ready = acc1;
  assign m.q        = q_r;
  assign m.q_valid  = q_valid_r;
  assign m.q_last   = q_last_r;
  assign m.q_msel   = q_msel_r;

endmodule

// File: tb/tb_dualmerge.sv
// Bench for dualmerge: ready tables per cycle plus a beat scoreboard on the merged output.
module tb_dualmerge;

  logic clk;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  dualmerge_if #(.WIDTH(8)) bif ();

  dualmerge #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .m     (bif.slave)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic       last;
    logic       msel;
  } beat_t;

  beat_t sb[$];

  typedef struct packed {
    logic v0, v1, qr;
    logic r0, r1;
  } cvec_t;

  typedef struct packed {
    logic       v0;
    logic [7:0] d0;
    logic       l0;
    logic       v1;
    logic [7:0] d1;
    logic       l1;
    logic       qr;
    logic       r0, r1;
  } svec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drv(input logic v0, input logic [7:0] d0, input logic l0,
                     input logic v1, input logic [7:0] d1, input logic l1, input logic qr);
    bif.d0_valid = v0; bif.d0 = d0; bif.d0_last = l0;
    bif.d1_valid = v1; bif.d1 = d1; bif.d1_last = l1;
    bif.q_ready  = qr;
  endtask

  // Scoreboard: pop the beat on q before pushing the beat accepted at the coming edge.
  always @(negedge clk) begin
    beat_t e;
    if (rst_n) begin
      if (bif.q_valid && bif.q_ready) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_beat", {bif.q, bif.q_last, bif.q_msel}, 32'hFFFF);
        end else begin
          e = sb.pop_front();
          chk("sb_beat", {bif.q, bif.q_last, bif.q_msel}, e);
        end
      end
      if (bif.d0_ready || bif.d1_ready)
        chk("ready_onehot", {bif.d0_ready, bif.d1_ready} == 2'b11, 0);
      if (bif.d0_valid && bif.d0_ready) sb.push_back({bif.d0, bif.d0_last, 1'b0});
      if (bif.d1_valid && bif.d1_ready) sb.push_back({bif.d1, bif.d1_last, 1'b1});
    end
  end

  cvec_t ctab[5];
  svec_t stab[11];

  initial begin
    ctab[0] = '{v0:0, v1:0, qr:1, r0:0, r1:0};
    ctab[1] = '{v0:1, v1:0, qr:1, r0:1, r1:0};
    ctab[2] = '{v0:0, v1:1, qr:1, r0:0, r1:1};
    ctab[3] = '{v0:1, v1:1, qr:1, r0:0, r1:1};
    ctab[4] = '{v0:1, v1:1, qr:0, r0:0, r1:0};

    stab[0]  = '{v0:0, d0:8'h00, l0:0, v1:1, d1:8'h22, l1:1, qr:1, r0:0, r1:1};
    stab[1]  = '{v0:1, d0:8'h11, l0:1, v1:1, d1:8'h22, l1:1, qr:1, r0:1, r1:0};
    stab[2]  = '{v0:1, d0:8'h11, l0:1, v1:1, d1:8'h22, l1:1, qr:1, r0:0, r1:1};
    stab[3]  = '{v0:1, d0:8'h11, l0:1, v1:1, d1:8'h22, l1:1, qr:1, r0:1, r1:0};
    stab[4]  = '{v0:1, d0:8'h11, l0:1, v1:1, d1:8'h22, l1:1, qr:1, r0:0, r1:1};
    stab[5]  = '{v0:1, d0:8'h11, l0:1, v1:0, d1:8'h00, l1:0, qr:1, r0:1, r1:0};
    stab[6]  = '{v0:1, d0:8'h44, l0:1, v1:1, d1:8'hA0, l1:0, qr:1, r0:0, r1:1};
    stab[7]  = '{v0:1, d0:8'h44, l0:1, v1:1, d1:8'hA1, l1:0, qr:1, r0:0, r1:1};
    stab[8]  = '{v0:1, d0:8'h44, l0:1, v1:1, d1:8'hA2, l1:1, qr:1, r0:0, r1:1};
    stab[9]  = '{v0:1, d0:8'h44, l0:1, v1:1, d1:8'hB0, l1:1, qr:1, r0:1, r1:0};
    stab[10] = '{v0:0, d0:8'h00, l0:0, v1:0, d1:8'h00, l1:0, qr:1, r0:0, r1:0};

    // Reset with both channels valid
    rst_n = 1'b0;
    drv(1, 8'h33, 1, 1, 8'h35, 1, 1);
    repeat (2) tick();
    #8;
    chk("rst_d0_ready", bif.d0_ready, 0);
    chk("rst_d1_ready", bif.d1_ready, 0);
    chk("rst_q_valid", bif.q_valid, 0);
    chk("rst_q", bif.q, 0);
    chk("rst_q_last", bif.q_last, 0);
    chk("rst_q_msel", bif.q_msel, 0);
    tick();
    rst_n = 1'b1;
    #8;
    chk("rel_d0_ready", bif.d0_ready, 1);
    chk("rel_d1_ready", bif.d1_ready, 0);
    tick();
    chk("rel_q", bif.q, 8'h33);
    chk("rel_q_msel", bif.q_msel, 0);
    chk("rel_q_valid", bif.q_valid, 1);

    // Combinational ready table: IDLE, prio=1, q_valid=1
    for (int i = 0; i < 5; i++) begin
      drv(ctab[i].v0, 8'h00, 1, ctab[i].v1, 8'h00, 1, ctab[i].qr);
      #1;
      chk($sformatf("comb_r0[%0d]", i), bif.d0_ready, ctab[i].r0);
      chk($sformatf("comb_r1[%0d]", i), bif.d1_ready, ctab[i].r1);
    end
    drv(0, 8'h00, 0, 0, 8'h00, 0, 1);
    tick();

    // Contention alternation then packet lock, one record per cycle
    for (int i = 0; i < 11; i++) begin
      drv(stab[i].v0, stab[i].d0, stab[i].l0, stab[i].v1, stab[i].d1, stab[i].l1, stab[i].qr);
      #8;
      chk($sformatf("seq_r0[%0d]", i), bif.d0_ready, stab[i].r0);
      chk($sformatf("seq_r1[%0d]", i), bif.d1_ready, stab[i].r1);
      tick();
    end

    // Backpressure with 0x5C pending
    drv(1, 8'h5C, 1, 0, 8'h00, 0, 1);
    #8;
    chk("bp_load_d0_ready", bif.d0_ready, 1);
    tick();
    drv(0, 8'h00, 0, 1, 8'h66, 1, 0);
    for (int i = 0; i < 4; i++) begin
      #8;
      chk("bp_q_hold", bif.q, 8'h5C);
      chk("bp_q_valid", bif.q_valid, 1);
      chk("bp_readies", {bif.d0_ready, bif.d1_ready}, 2'b00);
      tick();
    end
    bif.q_ready = 1'b1;
    #8;
    chk("bp_release_d1_ready", bif.d1_ready, 1);
    tick();
    chk("bp_next_q", bif.q, 8'h66);
    drv(0, 8'h00, 0, 0, 8'h00, 0, 1);
    tick();

    // Locked-channel stall
    drv(1, 8'h71, 0, 1, 8'h77, 1, 1);
    #8;
    chk("stall_first_d0_ready", bif.d0_ready, 1);
    tick();
    bif.d0_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #8;
      chk("stall_d1_ready", bif.d1_ready, 0);
      chk("stall_q_valid", bif.q_valid, (i == 0) ? 1 : 0);
      tick();
    end
    drv(1, 8'h72, 1, 1, 8'h77, 1, 1);
    #8;
    chk("stall_resume_d0_ready", bif.d0_ready, 1);
    chk("stall_resume_d1_ready", bif.d1_ready, 0);
    tick();
    bif.d0_valid = 1'b0;
    #8;
    chk("stall_after_d1_ready", bif.d1_ready, 1);
    tick();
    drv(0, 8'h00, 0, 0, 8'h00, 0, 1);
    tick();

    // Reset mid-packet
    drv(1, 8'hC0, 0, 0, 8'h00, 0, 1);
    tick();
    drv(1, 8'hC1, 0, 0, 8'h00, 0, 1);
    tick();
    drv(0, 8'h00, 0, 1, 8'hD0, 1, 1);
    #1;
    chk("midrst_locked_d1_ready", bif.d1_ready, 0);
    rst_n = 1'b0;
    #1;
    chk("midrst_q_valid_async", bif.q_valid, 0);
    chk("midrst_readies", {bif.d0_ready, bif.d1_ready}, 2'b00);
    sb.delete();
    tick();
    rst_n = 1'b1;
    #7;
    chk("midrst_d1_ready", bif.d1_ready, 1);
    tick();
    chk("midrst_q", {bif.q, bif.q_msel, bif.q_valid}, {8'hD0, 1'b1, 1'b1});
    drv(0, 8'h00, 0, 0, 8'h00, 0, 1);
    repeat (2) tick();

    chk("sb_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
